// File: rtl/axis_frame_tx.sv
// rtl/axis_frame_tx.sv - AXI-Stream frame transmitter streaming a host-loaded W x H grayscale buffer
// Two-entry output/skid pair fed from a synchronous-read RAM keeps one beat per clock under tready=1.
module axis_frame_tx #(
  parameter int W           = 64,
  parameter int H           = 64,
  parameter int TOTAL_PIXEL = W * H,
  parameter int ADDR_BIT    = $clog2(W * H),
  parameter int TIME_LIMIT  = 2_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [1:0]          status,
  output logic [1:0]          err_code,
  input  logic                wr_en,
  input  logic [ADDR_BIT-1:0] wr_addr,
  input  logic [7:0]          wr_data,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);
  localparam int             CW      = ADDR_BIT + 1;
  localparam logic [CW-1:0]  TOTAL   = CW'(TOTAL_PIXEL);
  localparam logic [CW-1:0]  LAST    = CW'(TOTAL_PIXEL - 1);
  localparam logic [31:0]    WD_LAST = 32'(TIME_LIMIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_STREAM, S_DONE, S_ERROR} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [TOTAL_PIXEL];
  logic [7:0]    ram_q;
  logic [CW-1:0] rd_ptr, beat_cnt;
  logic          rd_pend;
  logic [7:0]    skid_data;
  logic          skid_valid;
  logic [31:0]   wd_cnt;
  logic          active, pop, stall, last_pop, wr_err, timeout, rd_issue;
  logic [1:0]    held;

  assign active   = (state == S_PREFETCH) || (state == S_STREAM);
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign stall    = m_axis_tvalid & ~m_axis_tready;
  assign last_pop = pop && (beat_cnt == LAST);
  assign wr_err   = active && wr_en;
  assign timeout  = active && stall && (wd_cnt == WD_LAST);
  assign m_axis_tlast = m_axis_tvalid && (beat_cnt == LAST);

  // Pixels held after this edge (output + skid + landing read); a new read only fits below two.
  assign held     = 2'(m_axis_tvalid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
  assign rd_issue = active && !wr_err && !timeout && (rd_ptr < TOTAL) && (held < 2'd2);

  always_ff @(posedge clk) begin
    if (wr_en && !active && ({1'b0, wr_addr} < TOTAL)) mem[wr_addr] <= wr_data;
    if (rd_issue) ram_q <= mem[rd_ptr[ADDR_BIT-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:               if (start) state_nxt = S_PREFETCH;
      S_PREFETCH, S_STREAM: begin
        if (wr_err || timeout) state_nxt = S_ERROR;
        else if (last_pop)     state_nxt = S_DONE;
        else                   state_nxt = S_STREAM;
      end
      S_DONE, S_ERROR:      if (!start) state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    status = 2'd0;
    case (state)
      S_PREFETCH, S_STREAM: status = 2'd1;
      S_DONE:               status = 2'd2;
      S_ERROR:              status = 2'd3;
      default:              status = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_code <= 2'd0;
    else if (state_nxt == S_IDLE) err_code <= 2'd0;
    else if (wr_err)              err_code <= 2'd2;
    else if (timeout)             err_code <= 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      beat_cnt      <= '0;
      rd_pend       <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= 8'd0;
      wd_cnt        <= 32'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'd0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      // Leaving or outside the streaming states drops every buffered pixel (frame abort).
      if (!active || wr_err || timeout) begin
        rd_ptr        <= '0;
        beat_cnt      <= '0;
        skid_valid    <= 1'b0;
        wd_cnt        <= 32'd0;
        m_axis_tvalid <= 1'b0;
      end else begin
        if (pop)        beat_cnt <= beat_cnt + 1'b1;
        if (pop)        wd_cnt   <= 32'd0;
        else if (stall) wd_cnt   <= wd_cnt + 32'd1;
        if (!m_axis_tvalid || pop) begin
          if (skid_valid) begin
            m_axis_tdata  <= skid_data;
            m_axis_tvalid <= 1'b1;
            skid_valid    <= rd_pend;
            skid_data     <= ram_q;
          end else if (rd_pend) begin
            m_axis_tdata  <= ram_q;
            m_axis_tvalid <= 1'b1;
          end else begin
            m_axis_tvalid <= 1'b0;
          end
        end else if (rd_pend) begin
          skid_valid <= 1'b1;
          skid_data  <= ram_q;
        end
      end
    end
  end
endmodule
